// File: rtl/denise_bitplane_engine_if.sv
// ---------------------------------------------------------------------------
// denise_bitplane_engine_if
//   Bus and pixel-side signal bundle for the bitplane engine.
//   master : register bus / timing source (drives writes, enables, scroll)
//   slave  : bitplane engine (drives serial pixel bits and status)
//   Signals:
//     clk7_en, pix_en         enables (7MHz register slot, pixel advance)
//     reg_address_in [8:1]    register address
//     data_in, chip48         first fetch word and remaining wide fetch words
//     fetch_mode              00:16b 01/10:32b 11:64b
//     scroll_odd/even         PF1/PF2 scroll in pixels
//     bpldata, active, overrun engine outputs
// ---------------------------------------------------------------------------
interface denise_bitplane_engine_if #(
   parameter int NPLANES  = 8,
   parameter int SCROLL_W = 6
);
   logic                clk7_en;
   logic                pix_en;
   logic [8:1]          reg_address_in;
   logic [15:0]         data_in;
   logic [47:0]         chip48;
   logic [1:0]          fetch_mode;
   logic [SCROLL_W-1:0] scroll_odd;
   logic [SCROLL_W-1:0] scroll_even;
   logic [NPLANES-1:0]  bpldata;
   logic                active;
   logic                overrun;

   modport master (
      output clk7_en, pix_en, reg_address_in, data_in, chip48, fetch_mode,
             scroll_odd, scroll_even,
      input  bpldata, active, overrun
   );

   modport slave (
      input  clk7_en, pix_en, reg_address_in, data_in, chip48, fetch_mode,
             scroll_odd, scroll_even,
      output bpldata, active, overrun
   );
endinterface

// File: rtl/denise_bitplane_engine.sv
// ---------------------------------------------------------------------------
// denise_bitplane_engine
//   Captures up to NPLANES bitplane fetch words (16/32/64 bits) into holding
//   buffers, transfers them into shifters on a BPL1DAT write, and serialises
//   one bit per plane per pixel enable through a per-playfield scroll delay.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    denise_bitplane_engine_if.slave (register bus, enables, outputs)
// ---------------------------------------------------------------------------
module denise_bitplane_engine #(
   parameter int NPLANES  = 8,
   parameter int FETCH_W  = 64,
   parameter int SCROLL_W = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   denise_bitplane_engine_if.slave  bus
);

   localparam int              DEPTH        = 1 << SCROLL_W;
   localparam logic [7:0]      BPL1DAT_ADDR = 8'h88;   // 0x110 >> 1
   localparam logic [6:0]      FETCH_W7     = 7'(FETCH_W);
   localparam logic [63:0]     ONES64       = '1;

   typedef enum logic {ST_EMPTY = 1'b0, ST_ACTIVE = 1'b1} state_t;

   state_t                             state_q, state_d;
   logic [NPLANES-1:0][FETCH_W-1:0]    buf_q, buf_d;
   logic [NPLANES-1:0][FETCH_W-1:0]    shift_q, shift_d;
   logic [NPLANES-1:0][DEPTH-2:0]      dly_q, dly_d;
   logic [NPLANES-1:0]                 bpldata_q, bpldata_d;
   logic [6:0]                         cnt_q, cnt_d;
   logic [SCROLL_W-1:0]                scr_odd_q, scr_odd_d;
   logic [SCROLL_W-1:0]                scr_even_q, scr_even_d;
   logic                               load_req_q, load_req_d;
   logic                               overrun_q, overrun_d;

   logic                               active_s;
   logic                               load_s;
   logic                               bpl1_wr_s;
   logic [6:0]                         fetch_w_s;
   logic [63:0]                        word_s;
   logic [FETCH_W-1:0]                 wr_word_s;
   logic [NPLANES-1:0]                 msb_s;
   logic [NPLANES-1:0][DEPTH-1:0]      tap_s;
   logic [SCROLL_W-1:0]                sel_s;

   // Effective fetch width for a mode, clamped to the widest supported fetch.
   function automatic logic [6:0] fetch_width(input logic [1:0] mode);
      logic [6:0] w;
      case (mode)
         2'b00:   w = 7'd16;
         2'b11:   w = 7'd64;
         default: w = 7'd32;
      endcase
      return (w > FETCH_W7) ? FETCH_W7 : w;
   endfunction

   // Write decode and left-aligned, width-masked capture word.
   always_comb begin
      bpl1_wr_s = bus.clk7_en && (bus.reg_address_in == BPL1DAT_ADDR);
      load_s    = bus.clk7_en && load_req_q;
      fetch_w_s = fetch_width(bus.fetch_mode);
      word_s    = {bus.data_in, bus.chip48} & (ONES64 << (7'd64 - fetch_w_s));
      wr_word_s = word_s[63 -: FETCH_W];
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a load always (re)enters ACTIVE; the last pixel empties.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (load_s) state_d = ST_ACTIVE;
            else        state_d = ST_EMPTY;
         end
         ST_ACTIVE: begin
            if (load_s)                                state_d = ST_ACTIVE;
            else if (bus.pix_en && (cnt_q == 7'd1))    state_d = ST_EMPTY;
            else                                       state_d = ST_ACTIVE;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // FSM outputs: shifter MSBs only count as pixel data while ACTIVE.
   always_comb begin
      active_s = (state_q == ST_ACTIVE);
      for (int p = 0; p < NPLANES; p++) begin
         msb_s[p] = active_s & shift_q[p][FETCH_W-1];
      end
   end

   // Scroll delay taps: tap[0] is the live MSB, tap[k] the MSB k pixels ago.
   always_comb begin
      for (int p = 0; p < NPLANES; p++) begin
         tap_s[p] = {dly_q[p], msb_s[p]};
      end
   end

   // Datapath next state: buffers, shifters, counter, delay lines, outputs.
   always_comb begin
      buf_d      = buf_q;
      shift_d    = shift_q;
      dly_d      = dly_q;
      bpldata_d  = bpldata_q;
      cnt_d      = cnt_q;
      scr_odd_d  = scr_odd_q;
      scr_even_d = scr_even_q;
      overrun_d  = 1'b0;
      sel_s      = '0;

      for (int p = 0; p < NPLANES; p++) begin
         if (bus.clk7_en && (bus.reg_address_in == (BPL1DAT_ADDR + 8'(p)))) begin
            buf_d[p] = wr_word_s;
         end else begin
            buf_d[p] = buf_q[p];
         end
      end

      // Load takes buf_d so a buffer written in the load slot is included,
      // and suppresses the shift even if a pixel enable coincides.
      if (load_s) begin
         shift_d    = buf_d;
         cnt_d      = fetch_width(bus.fetch_mode);
         scr_odd_d  = bus.scroll_odd;
         scr_even_d = bus.scroll_even;
         overrun_d  = active_s && (cnt_q != 7'd0);
      end else if (bus.pix_en && active_s) begin
         for (int p = 0; p < NPLANES; p++) begin
            shift_d[p] = {shift_q[p][FETCH_W-2:0], 1'b0};
         end
         cnt_d = (cnt_q == 7'd0) ? 7'd0 : cnt_q - 7'd1;
      end else begin
         cnt_d = cnt_q;
      end

      // Delay lines run on every pixel enable, using the pre-load MSB.
      if (bus.pix_en) begin
         for (int p = 0; p < NPLANES; p++) begin
            sel_s        = (p % 2 == 0) ? scr_odd_q : scr_even_q;
            dly_d[p]     = tap_s[p][DEPTH-2:0];
            bpldata_d[p] = tap_s[p][sel_s];
         end
      end else begin
         dly_d     = dly_q;
         bpldata_d = bpldata_q;
      end

      if (bpl1_wr_s)   load_req_d = 1'b1;
      else if (load_s) load_req_d = 1'b0;
      else             load_req_d = load_req_q;
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q      <= '0;
         shift_q    <= '0;
         dly_q      <= '0;
         bpldata_q  <= '0;
         cnt_q      <= 7'd0;
         scr_odd_q  <= '0;
         scr_even_q <= '0;
         load_req_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         shift_q    <= shift_d;
         dly_q      <= dly_d;
         bpldata_q  <= bpldata_d;
         cnt_q      <= cnt_d;
         scr_odd_q  <= scr_odd_d;
         scr_even_q <= scr_even_d;
         load_req_q <= load_req_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.bpldata = bpldata_q;
   assign bus.active  = active_s;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_denise_bitplane_engine.sv
// ---------------------------------------------------------------------------
// tb_denise_bitplane_engine
//   Directed stimulus with a pixel-stream reference model: each plane holds a
//   pending word plus remaining-bit count and a pixel history, and outputs are
//   compared every clock. Hand-computed stream values pin the model.
// ---------------------------------------------------------------------------
module tb_denise_bitplane_engine;
   localparam int NP = 8;
   localparam int FW = 64;
   localparam int SW = 6;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   denise_bitplane_engine_if #(.NPLANES(NP), .SCROLL_W(SW)) bus ();

   denise_bitplane_engine #(.NPLANES(NP), .FETCH_W(FW), .SCROLL_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // reference model state
   logic [63:0]   m_buf  [NP];
   logic [63:0]   m_word [NP];
   logic [63:0]   m_hist [NP];   // bit k = pixel bit (k+1) pixel enables ago
   int            m_scr  [NP];
   int            m_cnt;
   logic          m_load_req;
   logic [NP-1:0] m_bpl;
   logic          m_ovr;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_buf[p]  = 64'd0;
         m_word[p] = 64'd0;
         m_hist[p] = 64'd0;
         m_scr[p]  = 0;
      end
      m_cnt      = 0;
      m_load_req = 1'b0;
      m_bpl      = '0;
      m_ovr      = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int            w;
      logic [63:0]   w64;
      logic [NP-1:0] msb;
      logic          load;
      w   = (bus.fetch_mode == 2'b00) ? 16 : (bus.fetch_mode == 2'b11) ? 64 : 32;
      if (w > FW) w = FW;
      w64 = {bus.data_in, bus.chip48};
      for (int i = 0; i < 64; i++) if (i < 64 - w) w64[i] = 1'b0;
      load = bus.clk7_en && m_load_req;
      for (int p = 0; p < NP; p++) begin
         msb[p] = (m_cnt > 0) ? m_word[p][63] : 1'b0;
         if (bus.clk7_en && (bus.reg_address_in == 8'h88 + p)) m_buf[p] = w64;
      end
      if (bus.pix_en) begin
         for (int p = 0; p < NP; p++) begin
            m_bpl[p]  = (m_scr[p] == 0) ? msb[p] : m_hist[p][m_scr[p] - 1];
            m_hist[p] = {m_hist[p][62:0], msb[p]};
         end
      end
      if (load) begin
         m_ovr = (m_cnt > 0);
         for (int p = 0; p < NP; p++) begin
            m_word[p] = m_buf[p];
            m_scr[p]  = (p % 2 == 0) ? int'(bus.scroll_odd) : int'(bus.scroll_even);
         end
         m_cnt = w;
      end else begin
         m_ovr = 1'b0;
         if (bus.pix_en && m_cnt > 0) begin
            for (int p = 0; p < NP; p++) m_word[p] = m_word[p] << 1;
            m_cnt--;
         end
      end
      if (bus.clk7_en && bus.reg_address_in == 8'h88) m_load_req = 1'b1;
      else if (load) m_load_req = 1'b0;
   endtask

   // One clock: model, edge, then compare every output.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("bpldata", bus.bpldata, m_bpl);
      check("active", bus.active, m_cnt > 0);
      check("overrun", bus.overrun, m_ovr);
   endtask

   task automatic bus_write(input int plane, input logic [15:0] d, input logic [47:0] c);
      bus.reg_address_in = 8'(8'h88 + plane - 1);
      bus.data_in        = d;
      bus.chip48         = c;
      tick();
      bus.reg_address_in = 8'h00;
   endtask

   task automatic pixels(input int n);
      bus.pix_en = 1'b1;
      repeat (n) tick();
      bus.pix_en = 1'b0;
   endtask

   logic [15:0] s16;
   logic [63:0] s64;
   logic [3:0]  s4;
   int          f0, f1;

   initial begin
      reset              = 1'b1;
      bus.clk7_en        = 1'b0;
      bus.pix_en         = 1'b0;
      bus.reg_address_in = 8'h00;
      bus.data_in        = 16'h0000;
      bus.chip48         = 48'h0;
      bus.fetch_mode     = 2'b00;
      bus.scroll_odd     = '0;
      bus.scroll_even    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_bpldata", bus.bpldata, 64'd0);
      check("reset_active", bus.active, 64'd0);
      check("reset_overrun", bus.overrun, 64'd0);
      reset       = 1'b0;
      bus.clk7_en = 1'b1;

      // 1: 16-bit fetch, scroll 0
      bus_write(1, 16'h8001, 48'h0);
      tick();                                   // load slot
      bus.pix_en = 1'b1;
      s16 = 16'h0;
      for (int i = 0; i < 16; i++) begin
         tick();
         s16 = {s16[14:0], bus.bpldata[0]};
         if (i == 14) check("t1_active_pix15", bus.active, 64'd1);
      end
      bus.pix_en = 1'b0;
      check("t1_stream", s16, 16'h8001);
      check("t1_active_end", bus.active, 64'd0);

      // 2: 64-bit fetch
      bus.fetch_mode = 2'b11;
      bus_write(1, 16'h0F0F, 48'hFFFF_0000_AAAA);
      tick();
      bus.pix_en = 1'b1;
      s64 = 64'h0;
      for (int i = 0; i < 64; i++) begin
         tick();
         s64 = {s64[62:0], bus.bpldata[0]};
      end
      check("t2_stream", s64, 64'h0F0F_FFFF_0000_AAAA);
      check("t2_active_end", bus.active, 64'd0);
      pixels(8);                                // flush delay history

      // 3: PF1 scroll 5 vs PF2 scroll 0; plane 2 written in the load slot
      bus.fetch_mode  = 2'b00;
      bus.scroll_odd  = 6'd5;
      bus.scroll_even = 6'd0;
      bus_write(1, 16'h8000, 48'h0);
      bus_write(2, 16'h8000, 48'h0);
      bus.pix_en = 1'b1;
      f0 = -1;
      f1 = -1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (f0 < 0 && bus.bpldata[0]) f0 = i;
         if (f1 < 0 && bus.bpldata[1]) f1 = i;
      end
      bus.pix_en = 1'b0;
      check("t3_plane2_first", 64'(f1), 64'd0);
      check("t3_plane1_first", 64'(f0), 64'd5);

      // 4: reload after 10 of 16 pixels
      bus.scroll_odd = 6'd0;
      bus_write(1, 16'hFFFF, 48'h0);
      tick();
      pixels(10);
      bus_write(1, 16'h0001, 48'h0);
      tick();
      check("t4_overrun_pulse", bus.overrun, 64'd1);
      bus.pix_en = 1'b1;
      s16 = 16'h0;
      for (int i = 0; i < 16; i++) begin
         tick();
         s16 = {s16[14:0], bus.bpldata[0]};
         if (i == 0) check("t4_overrun_clear", bus.overrun, 64'd0);
      end
      bus.pix_en = 1'b0;
      check("t4_stream", s16, 16'h0001);

      // 5: load coincides with pixel enable
      bus_write(1, 16'hA000, 48'h0);
      bus.pix_en = 1'b1;
      tick();
      check("t5_preload_bit", bus.bpldata[0], 64'd0);
      check("t5_active", bus.active, 64'd1);
      s4 = 4'h0;
      for (int i = 0; i < 4; i++) begin
         tick();
         s4 = {s4[2:0], bus.bpldata[0]};
      end
      check("t5_stream", s4, 4'hA);
      pixels(12);

      // 6: reset mid-stream with scroll 3 and a load pending
      bus.scroll_odd  = 6'd3;
      bus.scroll_even = 6'd3;
      bus_write(1, 16'hFFFF, 48'h0);
      tick();
      pixels(9);
      check("t6_prereset_bit", bus.bpldata[0], 64'd1);
      bus_write(1, 16'h1234, 48'h0);            // load request pending
      bus.clk7_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("t6_reset_bpldata", bus.bpldata, 64'd0);
      check("t6_reset_active", bus.active, 64'd0);
      check("t6_reset_overrun", bus.overrun, 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b0;
      bus.clk7_en = 1'b1;
      repeat (3) tick();
      check("t6_no_load_after_reset", bus.active, 64'd0);
      pixels(5);
      check("t6_no_output", bus.bpldata, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
